// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-outstanding instruction-fetch controller.
// Issues one imem request at a time and hands each returned word to decode via valid/ready.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_to_pc,
  input  logic        io_redirect,
  output logic [31:0] io_pc,
  output logic [31:0] io_pc_4,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_inst_valid,
  output logic [31:0] io_inst,
  output logic [31:0] io_inst_pc,
  input  logic        io_dec_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        w_dec_fire;
  logic        w_pc_load;
  logic        w_capture;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_REQ: begin
        if (io_imem_req_ready) begin
          w_next_state = io_redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_redirect) begin
          w_next_state = io_imem_resp_valid ? S_REQ : S_DROP;
        end else if (io_imem_resp_valid) begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (io_redirect || io_dec_ready) begin
          w_next_state = S_REQ;
        end
      end
      S_DROP: begin
        if (io_imem_resp_valid) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  // Request is masked during reset so nothing is issued before release.
  always_comb begin
    io_imem_req_valid = (r_state == S_REQ) && !reset;
    io_inst_valid     = (r_state == S_HOLD) && !io_redirect;
  end

  assign w_dec_fire = io_inst_valid && io_dec_ready;
  assign w_pc_load  = io_redirect || w_dec_fire;
  assign w_capture  = (r_state == S_WAIT) && io_imem_resp_valid && !io_redirect;

  // NOTE: every register here is a plain flop with a defined reset value;
  // there is no memory array, so nothing is left uninitialised.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_VECTOR;
      r_inst    <= 32'h0;
      r_inst_pc <= 32'h0;
    end else begin
      if (w_pc_load) begin
        r_pc <= io_to_pc & 32'hFFFF_FFFC;
      end
      if (w_capture) begin
        r_inst    <= io_imem_resp_data;
        r_inst_pc <= r_pc;
      end
    end
  end

  assign io_pc            = r_pc;
  assign io_pc_4          = r_pc + 32'd4;
  assign io_imem_req_addr = r_pc;
  assign io_inst          = r_inst;
  assign io_inst_pc       = r_inst_pc;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and single-outstanding instruction-fetch controller, directly downstream of the PC select mux. Holds the architectural PC and supplies `io_pc` and `io_pc_4` back to the mux. Loads the mux result `io_to_pc` whenever an instruction retires to decode or a redirect occurs. Issues one instruction-memory request at a time and presents the returned word to decode with a valid/ready handshake.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value after reset; must be word-aligned.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `io_to_pc`  in  32: next-PC from the PC select mux.
- `io_redirect`  in  1: jump/branch redirect pulse; loads `io_to_pc` and squashes any in-flight fetch.
- `io_pc`  out  32: current PC register.
- `io_pc_4`  out  32: `io_pc + 4`, modulo 2^32.
- `io_imem_req_valid`  out  1: fetch request valid.
- `io_imem_req_ready`  in  1: memory accepts the request.
- `io_imem_req_addr`  out  32: fetch address; always equals `io_pc`.
- `io_imem_resp_valid`  in  1: response word valid (one cycle per accepted request).
- `io_imem_resp_data`  in  32: instruction word.
- `io_inst_valid`  out  1: instruction held for decode.
- `io_inst`  out  32: held instruction.
- `io_inst_pc`  out  32: PC the held instruction was fetched from.
- `io_dec_ready`  in  1: decode accepts the instruction.

## Operation
- States: REQ, WAIT, HOLD, DROP. Reset enters REQ.
- PC load rule: `pc <= {io_to_pc[31:2], 2'b00}`; the low two bits are always cleared. The PC loads only on an accepted decode handshake or on `io_redirect`, and otherwise holds.
- REQ: `io_imem_req_valid` = 1.
  - `io_imem_req_ready` = 1 -> WAIT.
  - Otherwise stay in REQ.
- WAIT: `io_imem_req_valid` = 0.
  - `io_imem_resp_valid` = 1 -> capture `io_inst <= io_imem_resp_data` and `io_inst_pc <= pc`, then go to HOLD.
- HOLD: `io_inst_valid = !io_redirect`.
  - `io_inst_valid && io_dec_ready` -> load PC from `io_to_pc`, then go to REQ.
  - Otherwise hold the instruction and its PC stable.
- DROP: one request is outstanding whose response must be discarded.
  - `io_imem_resp_valid` = 1 -> REQ; the data is not captured.
- Redirect takes priority over every other event in every state; the PC always loads `io_to_pc`. Next state on redirect:
  - REQ with `io_imem_req_ready` = 1 (old-address request accepted) -> DROP.
  - REQ with `io_imem_req_ready` = 0 -> REQ; the next cycle requests the new PC.
  - WAIT with `io_imem_resp_valid` = 1 -> REQ; the response is discarded.
  - WAIT with `io_imem_resp_valid` = 0 -> DROP.
  - HOLD -> REQ; the instruction is discarded and `io_inst_valid` is forced low that cycle.
  - DROP -> DROP if no response arrives this cycle, else REQ.
- `io_imem_resp_valid` is ignored in REQ and HOLD.
- At most one memory request is outstanding at any time.

## Timing
- Reset values:
  - `io_pc` = `RESET_VECTOR`; `io_pc_4` = `RESET_VECTOR` + 4.
  - `io_imem_req_valid` = 0 while `reset` is high; 1 in the first cycle after release.
  - `io_inst_valid` = 0; `io_inst` = 0; `io_inst_pc` = 0; state = REQ.
- Outputs:
  - `io_pc_4` and `io_imem_req_addr` are combinational from the PC register.
  - `io_imem_req_valid` and `io_inst_valid` are combinational from state (and `io_redirect`).
- Best-case throughput: one instruction per 3 cycles. Request accepted in cycle N, response in N+1, `io_inst_valid` in N+2 with the decode handshake, new request in N+3.
- Reset asserted mid-operation: all state returns to reset values immediately. A response arriving after reset release while in REQ is ignored.

## Test plan
- Reset release, `RESET_VECTOR` = 0x0000_1000, ready and response always 1 (`resp_data` = 0x0000_0013), `io_to_pc` = pc+4 -> request addresses 0x1000, 0x1004, 0x1008 on cycles 0, 3, 6; `io_inst_pc` matches each.
- `io_imem_req_ready` low for 4 cycles -> `req_valid` stays high with `req_addr` stable at 0x1000; WAIT entered only on the cycle ready rises.
- Decode back-pressure: `io_dec_ready` = 0 for 5 cycles in HOLD -> `io_inst`/`io_inst_pc` stable, PC unchanged, no new request; PC loads `io_to_pc` on the ready cycle.
- Redirect in WAIT, no response, `io_to_pc` = 0x0000_2000 -> DROP; a later response 0xDEAD_BEEF is not presented; next request address is 0x2000.
- Redirect in HOLD with `io_dec_ready` = 1, `io_to_pc` = 0x0000_3002 -> `io_inst_valid` low that cycle; PC = 0x3000; next request is to 0x3000.
- Async reset asserted mid-WAIT -> outputs take reset values before the next clock edge; a subsequent stray response is ignored.
